// File: rtl/uart_msg_pkg.sv
// Shared types and constants for the "Hello World\r\n" UART message sequencer.
// Define UART_SEQ_NUM_EN to insert a two-digit hex message counter before CR/LF.
package uart_msg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int unsigned MSG_BASE_LEN = 13;
    localparam int unsigned MSG_TEXT_LEN = 11;

`ifdef UART_SEQ_NUM_EN
    localparam int unsigned MSG_LEN = MSG_BASE_LEN + 2;
`else
    localparam int unsigned MSG_LEN = MSG_BASE_LEN;
`endif

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // "Hello World"; the CR/LF terminator is appended by the ROM.
    localparam logic [7:0] MSG_TEXT [MSG_TEXT_LEN] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
        8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64
    };

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_msg_rom.sv
// Combinational message ROM: byte index -> ASCII byte.
// With UART_SEQ_NUM_EN the sequence digits sit at indices 11/12, before CR/LF.
module uart_msg_rom
    import uart_msg_pkg::*;
(
    input  logic [3:0] idx_i,
`ifdef UART_SEQ_NUM_EN
    input  logic [7:0] seq_i,
`endif
    output logic [7:0] byte_o
);

    always_comb begin
        byte_o = '0;
        if (idx_i < 4'(MSG_TEXT_LEN)) begin
            byte_o = MSG_TEXT[idx_i];
        end else begin
`ifdef UART_SEQ_NUM_EN
            case (idx_i)
                4'd11:   byte_o = hex_ascii(seq_i[7:4]);
                4'd12:   byte_o = hex_ascii(seq_i[3:0]);
                4'd13:   byte_o = CHAR_CR;
                4'd14:   byte_o = CHAR_LF;
                default: byte_o = '0;
            endcase
`else
            case (idx_i)
                4'd11:   byte_o = CHAR_CR;
                4'd12:   byte_o = CHAR_LF;
                default: byte_o = '0;
            endcase
`endif
        end
    end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Feeds the fixed message into a UART TX byte port over valid/ready, one message per trigger.
// Optional UART_SEQ_NUM_EN appends a per-message hex sequence number.
module uart_msg_sequencer
    import uart_msg_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done
);

    state_e                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic                   pending_q, pending_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q;
    logic                   done_q, done_d;
    logic                   load;
    logic                   accept;
    logic [7:0]             rom_byte;

    assign accept = tx_valid_q & tx_ready;

`ifdef UART_SEQ_NUM_EN
    logic [7:0] msg_cnt_q;
    logic [7:0] seq_q;

    // Digits are frozen at byte 0 so a mid-message counter change cannot tear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt_q <= '0;
            seq_q     <= '0;
        end else begin
            if (done_q) begin
                msg_cnt_q <= msg_cnt_q + 8'd1;
            end
            if (accept && idx_q == 4'd0) begin
                seq_q <= msg_cnt_q;
            end
        end
    end
`endif

    // ROM is addressed by the next index so tx_data can be registered with tx_valid.
    uart_msg_rom u_rom (
        .idx_i  (idx_d),
`ifdef UART_SEQ_NUM_EN
        .seq_i  (seq_q),
`endif
        .byte_o (rom_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            pending_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            if (load) begin
                tx_data_q <= rom_byte;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        pending_d  = pending_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        load       = 1'b0;

        if (trigger && state_q != ST_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger || pending_q) begin
                    state_d    = ST_SEND;
                    idx_d      = '0;
                    pending_d  = 1'b0;
                    tx_valid_d = 1'b1;
                    load       = 1'b1;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    if (idx_q == 4'(MSG_LEN - 1)) begin
                        state_d    = ST_DONE;
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (GAP_CYCLES == 0) begin
                            tx_valid_d = 1'b1;
                            load       = 1'b1;
                        end else begin
                            state_d    = ST_GAP;
                            gap_d      = GAP_WIDTH'(GAP_CYCLES);
                            tx_valid_d = 1'b0;
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - GAP_WIDTH'(1);
                if (gap_q == GAP_WIDTH'(1)) begin
                    state_d    = ST_SEND;
                    tx_valid_d = 1'b1;
                    load       = 1'b1;
                end
            end
            ST_DONE: begin
                // A trigger arriving here is already latched into pending_d above.
                if (pending_q) begin
                    state_d    = ST_SEND;
                    idx_d      = '0;
                    pending_d  = 1'b0;
                    tx_valid_d = 1'b1;
                    load       = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
